// File: rtl/conv_channel_replay.sv
// conv_channel_replay: captures one channel plane into RAM and replays it
// CHANNEL_NUM_OUT times at a fixed plane pitch for the channel adder chain.
module conv_channel_replay #(
    parameter int DATA_WIDTH      = 32,
    parameter int IMAGE_SIZE      = 612,
    parameter int IMAGE_WIDTH     = 12,
    parameter int RATE            = 1,
    parameter int CHANNEL_NUM_OUT = 64,
    parameter int PLANE_PITCH     = IMAGE_SIZE + IMAGE_WIDTH * RATE + RATE,
    parameter int ADDR_W          = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1,
    parameter int CH_W            = $clog2(CHANNEL_NUM_OUT + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic                  ready_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic [CH_W-1:0]       channel_idx,
    output logic                  last_out,
    output logic                  busy
);

    localparam int GAP_LEN  = PLANE_PITCH - IMAGE_SIZE;
    localparam int GAP_W    = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    localparam int GAP_LIM  = (GAP_LEN > 0) ? GAP_LEN - 1 : 0;

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IMAGE_SIZE - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(CHANNEL_NUM_OUT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_LIM);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_EMIT,
        S_GAP
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CH_W-1:0]   ch_cnt_q, ch_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;

    logic [DATA_WIDTH-1:0] ram_q [IMAGE_SIZE];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_v_q;
    logic [CH_W-1:0]       rd_ch_q;
    logic                  rd_last_q;

    logic [DATA_WIDTH-1:0] pxl_out_q;
    logic                  valid_out_q;
    logic [CH_W-1:0]       ch_out_q;
    logic                  last_out_q;

    logic              we;
    logic              rd_en;
    logic              rd_last;
    logic [ADDR_W-1:0] wr_addr;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            ch_cnt_q  <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            ch_cnt_q  <= ch_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // Next state and counter updates
    always_comb begin
        state_d   = state_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        ch_cnt_d  = ch_cnt_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (valid_in) begin
                    wr_cnt_d = ADDR_W'(1);
                    rd_cnt_d = '0;
                    ch_cnt_d = '0;
                    state_d  = (IMAGE_SIZE == 1) ? S_EMIT : S_LOAD;
                end
            end
            S_LOAD: begin
                if (valid_in) begin
                    if (wr_cnt_q == ADDR_LAST) begin
                        state_d  = S_EMIT;
                        wr_cnt_d = '0;
                        rd_cnt_d = '0;
                        ch_cnt_d = '0;
                    end else begin
                        wr_cnt_d = wr_cnt_q + ADDR_W'(1);
                    end
                end
            end
            S_EMIT: begin
                if (rd_cnt_q == ADDR_LAST) begin
                    if (ch_cnt_q == CH_LAST) begin
                        state_d = S_IDLE;
                    end else if (GAP_LEN == 0) begin
                        rd_cnt_d = '0;
                        ch_cnt_d = ch_cnt_q + CH_W'(1);
                    end else begin
                        state_d   = S_GAP;
                        gap_cnt_d = '0;
                    end
                end else begin
                    rd_cnt_d = rd_cnt_q + ADDR_W'(1);
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d  = S_EMIT;
                    rd_cnt_d = '0;
                    ch_cnt_d = ch_cnt_q + CH_W'(1);
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Decoded controls; busy covers the two-stage drain after the last read
    always_comb begin
        ready_in = (state_q == S_IDLE) || (state_q == S_LOAD);
        rd_en    = (state_q == S_EMIT);
        we       = valid_in && ready_in;
        wr_addr  = (state_q == S_IDLE) ? '0 : wr_cnt_q;
        rd_last  = rd_en && (rd_cnt_q == ADDR_LAST) && (ch_cnt_q == CH_LAST);
        busy     = (state_q != S_IDLE) || rd_v_q || valid_out_q;
    end

    // Plane RAM: write port during capture, synchronous read during replay
    always_ff @(posedge clk) begin
        if (we) begin
            ram_q[wr_addr] <= pxl_in;
        end
        if (rd_en) begin
            rd_data_q <= ram_q[rd_cnt_q];
        end
    end

    // Read-stage sideband, aligned with rd_data_q
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_v_q    <= 1'b0;
            rd_ch_q   <= '0;
            rd_last_q <= 1'b0;
        end else begin
            rd_v_q    <= rd_en;
            rd_ch_q   <= ch_cnt_q;
            rd_last_q <= rd_last;
        end
    end

    // Output register; data and channel hold while no pixel is valid
    always_ff @(posedge clk) begin
        if (reset) begin
            pxl_out_q   <= '0;
            valid_out_q <= 1'b0;
            ch_out_q    <= '0;
            last_out_q  <= 1'b0;
        end else begin
            valid_out_q <= rd_v_q;
            last_out_q  <= rd_last_q;
            if (rd_v_q) begin
                pxl_out_q <= rd_data_q;
                ch_out_q  <= rd_ch_q;
            end
        end
    end

    assign pxl_out     = pxl_out_q;
    assign valid_out   = valid_out_q;
    assign channel_idx = ch_out_q;
    assign last_out    = last_out_q;

endmodule

// File: tb/tb_conv_channel_replay.sv
// Testbench for conv_channel_replay: directed captures with a timed
// scoreboard of expected replay pixels for pitch-6 and pitch-4 instances.
module tb_conv_channel_replay;

    localparam int DW = 32;
    localparam int IS = 4;
    localparam int CN = 3;
    localparam int CW = $clog2(CN + 1);

    typedef struct {
        logic [DW-1:0] px;
        int            ch;
        bit            last;
        int            at;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          valid_in = 1'b0;
    logic [DW-1:0] pxl_in = '0;
    logic          ready_in;
    logic [DW-1:0] pxl_out;
    logic          valid_out;
    logic [CW-1:0] channel_idx;
    logic          last_out;
    logic          busy;

    logic          valid_in4 = 1'b0;
    logic [DW-1:0] pxl_in4 = '0;
    logic          ready_in4;
    logic [DW-1:0] pxl_out4;
    logic          valid_out4;
    logic [CW-1:0] channel_idx4;
    logic          last_out4;
    logic          busy4;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t q4[$];
    exp_t e0;
    exp_t e1;
    logic [DW-1:0] img [4];
    int   w;
    int   w2;

    conv_channel_replay #(
        .DATA_WIDTH(DW), .IMAGE_SIZE(IS), .IMAGE_WIDTH(1), .RATE(1),
        .CHANNEL_NUM_OUT(CN), .PLANE_PITCH(6)
    ) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
        .ready_in(ready_in), .pxl_out(pxl_out), .valid_out(valid_out),
        .channel_idx(channel_idx), .last_out(last_out), .busy(busy)
    );

    conv_channel_replay #(
        .DATA_WIDTH(DW), .IMAGE_SIZE(IS), .IMAGE_WIDTH(1), .RATE(1),
        .CHANNEL_NUM_OUT(CN), .PLANE_PITCH(4)
    ) dut4 (
        .clk(clk), .reset(reset), .valid_in(valid_in4), .pxl_in(pxl_in4),
        .ready_in(ready_in4), .pxl_out(pxl_out4), .valid_out(valid_out4),
        .channel_idx(channel_idx4), .last_out(last_out4), .busy(busy4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pitch-6 scoreboard monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_valid", 64'(valid_out), 64'd0);
            end else begin
                e0 = q.pop_front();
                check("pxl", 64'(pxl_out), 64'(e0.px));
                check("ch", 64'(channel_idx), 64'(e0.ch));
                check("last", 64'(last_out), 64'(e0.last));
                check("time", 64'(cyc), 64'(e0.at));
            end
        end
    end

    // Pitch-4 scoreboard monitor
    always @(negedge clk) begin
        if (valid_out4 === 1'b1) begin
            if (q4.size() == 0) begin
                check("unexpected_valid4", 64'(valid_out4), 64'd0);
            end else begin
                e1 = q4.pop_front();
                check("pxl4", 64'(pxl_out4), 64'(e1.px));
                check("ch4", 64'(channel_idx4), 64'(e1.ch));
                check("last4", 64'(last_out4), 64'(e1.last));
                check("time4", 64'(cyc), 64'(e1.at));
            end
        end
    end

    task automatic expect_replay(input int wedge, input int pitch,
                                 input bit sel);
        exp_t e;
        for (int k = 0; k < CN; k++) begin
            for (int p = 0; p < IS; p++) begin
                e.px   = img[p];
                e.ch   = k;
                e.last = (k == CN - 1) && (p == IS - 1);
                e.at   = wedge + 2 + k * pitch + p;
                if (sel) q4.push_back(e);
                else     q.push_back(e);
            end
        end
    endtask

    task automatic drive(input bit sel, input bit v, input logic [DW-1:0] x);
        @(posedge clk);
        #1;
        if (sel) begin
            valid_in4 = v;
            pxl_in4   = x;
        end else begin
            valid_in = v;
            pxl_in   = x;
        end
    endtask

    task automatic feed4(input bit sel, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [DW-1:0] c,
                         input logic [DW-1:0] d, output int wedge);
        img[0] = a;
        img[1] = b;
        img[2] = c;
        img[3] = d;
        drive(sel, 1'b1, a);
        drive(sel, 1'b1, b);
        drive(sel, 1'b1, c);
        drive(sel, 1'b1, d);
        wedge = cyc + 1;
        expect_replay(wedge, sel ? 4 : 6, sel);
        drive(sel, 1'b0, '0);
    endtask

    task automatic wait_until(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(valid_out), 64'd0);
        check("rst_pxl", 64'(pxl_out), 64'd0);
        check("rst_ch", 64'(channel_idx), 64'd0);
        check("rst_last", 64'(last_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(ready_in), 64'd1);
        reset = 1'b0;

        // 1: gapless capture, pitch 6, with drain boundary checks
        feed4(1'b0, 32'd1, 32'd2, 32'd3, 32'd4, w);
        check("t1_ready_emit", 64'(ready_in), 64'd0);
        check("t1_busy_emit", 64'(busy), 64'd1);
        wait_until(w + 15);
        check("t1_ready_lastrd", 64'(ready_in), 64'd0);
        wait_until(w + 16);
        check("t1_ready_idle", 64'(ready_in), 64'd1);
        check("t1_busy_drain1", 64'(busy), 64'd1);
        wait_until(w + 17);
        check("t1_last", 64'(last_out), 64'd1);
        check("t1_busy_drain2", 64'(busy), 64'd1);
        wait_until(w + 18);
        check("t1_busy_done", 64'(busy), 64'd0);
        check("t1_valid_done", 64'(valid_out), 64'd0);
        check("t1_pxl_hold", 64'(pxl_out), 64'd4);
        check("t1_ch_hold", 64'(channel_idx), 64'd2);

        // 2: gappy capture behaves like a gapless one timed from D
        img[0] = 32'hA;
        img[1] = 32'hB;
        img[2] = 32'hC;
        img[3] = 32'hD;
        drive(1'b0, 1'b1, 32'hA);
        drive(1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 32'hB);
        drive(1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 32'hC);
        drive(1'b0, 1'b1, 32'hD);
        w = cyc + 1;
        expect_replay(w, 6, 1'b0);
        drive(1'b0, 1'b0, '0);
        wait_until(w + 18);

        // 3: pixels offered during replay are dropped
        feed4(1'b0, 32'd11, 32'd12, 32'd13, 32'd14, w);
        for (int c = 0; c < 14; c++) begin
            drive(1'b0, 1'b1, 32'd99);
            check("t3_ready_low", 64'(ready_in), 64'd0);
        end
        drive(1'b0, 1'b0, '0);
        wait_until(w + 18);
        check("t3_idle_ready", 64'(ready_in), 64'd1);

        // 4: pitch equal to plane size gives a continuous burst
        feed4(1'b1, 32'd101, 32'd102, 32'd103, 32'd104, w);
        wait_until(w + 16);
        check("t4_busy_done", 64'(busy4), 64'd0);

        // 5: reset in the middle of plane 1, then a fresh capture
        feed4(1'b0, 32'd21, 32'd22, 32'd23, 32'd24, w);
        wait_until(w + 8);
        reset = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        check("t5_valid", 64'(valid_out), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_ready", 64'(ready_in), 64'd1);
        check("t5_ch", 64'(channel_idx), 64'd0);
        reset = 1'b0;
        feed4(1'b0, 32'd5, 32'd6, 32'd7, 32'd8, w);
        wait_until(w + 18);

        // 6: second capture starts on the first IDLE cycle
        feed4(1'b0, 32'd31, 32'd32, 32'd33, 32'd34, w);
        wait_until(w + 15);
        feed4(1'b0, 32'd41, 32'd42, 32'd43, 32'd44, w2);
        check("t6_back_to_back_edge", 64'(w2), 64'(w + 20));
        wait_until(w2 + 18);

        // Drain and make sure nothing is left or extra
        repeat (10) @(posedge clk);
        #1;
        check("drain_q", 64'(q.size()), 64'd0);
        check("drain_q4", 64'(q4.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
